// File: rtl/wb_multi_counter.sv
// NCH independent BITS-wide up/down counters with limit, one-shot and sticky
// terminal-count flags, reached through a valid/ready register port.
module wb_multi_counter #(
    parameter int BITS   = 16,
    parameter int NCH    = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic [3:0]        wstrb,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic [31:0]       rdata,
    input  logic [BITS-1:0]   la_write,
    input  logic [BITS-1:0]   la_input,
    output logic [BITS-1:0]   count0,
    output logic              irq
);

    localparam int CW = ADDR_W - 4;

    typedef enum logic [1:0] {
        REG_COUNT  = 2'd0,
        REG_LIMIT  = 2'd1,
        REG_CTRL   = 2'd2,
        REG_STATUS = 2'd3
    } reg_e;

    logic [BITS-1:0] count_q [NCH];
    logic [BITS-1:0] limit_q [NCH];
    logic [BITS-1:0] count_d [NCH];
    logic [BITS-1:0] limit_d [NCH];
    logic [NCH-1:0]  en_q, down_q, oneshot_q, irq_en_q, tc_q;
    logic [NCH-1:0]  en_d, down_d, oneshot_d, irq_en_d, tc_d;
    logic [NCH-1:0]  tc_set;
    logic [NCH-1:0]  ch_hit;
    logic [NCH-1:0]  wr_hit;
    logic            access;
    logic            is_write;
    logic [CW-1:0]   ch_idx;
    reg_e            reg_sel;
    logic [31:0]     rd_val;
    logic [BITS-1:0] lane_mask;
    logic [BITS-1:0] wdata_bits;
    logic            unused_ok;

    // Upper address bits take part in the channel index so that any address
    // past the last channel decodes to nothing rather than aliasing.
    assign access     = valid && !ready;
    assign is_write   = access && (wstrb != 4'b0000);
    assign ch_idx     = addr[ADDR_W-1:4];
    assign reg_sel    = reg_e'(addr[3:2]);
    assign wr_hit     = is_write ? ch_hit : '0;
    assign wdata_bits = wdata[BITS-1:0];
    assign unused_ok  = &{1'b0, addr[1:0], wdata};

    always_comb begin
        lane_mask = '0;
        for (int b = 0; b < BITS; b++) begin
            lane_mask[b] = wstrb[b / 8];
        end
    end

    always_comb begin
        ch_hit = '0;
        rd_val = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_idx == CW'(i)) begin
                ch_hit[i] = 1'b1;
                case (reg_sel)
                    REG_COUNT:  rd_val = 32'(count_q[i]);
                    REG_LIMIT:  rd_val = 32'(limit_q[i]);
                    REG_CTRL:   rd_val = {28'd0, irq_en_q[i], oneshot_q[i], down_q[i], en_q[i]};
                    REG_STATUS: rd_val = {31'd0, tc_q[i]};
                    default:    rd_val = '0;
                endcase
            end
        end
    end

    // Per channel: bus COUNT write beats LA load beats the count step; the step
    // always sees the en value from before any CTRL write on the same edge.
    always_comb begin
        tc_set    = '0;
        en_d      = en_q;
        down_d    = down_q;
        oneshot_d = oneshot_q;
        irq_en_d  = irq_en_q;
        tc_d      = tc_q;
        for (int i = 0; i < NCH; i++) begin
            count_d[i] = count_q[i];
            limit_d[i] = limit_q[i];

            if (wr_hit[i] && reg_sel == REG_COUNT) begin
                count_d[i] = (count_q[i] & ~lane_mask) | (wdata_bits & lane_mask);
            end else if (i == 0 && la_write != '0) begin
                count_d[i] = (count_q[i] & ~la_write) | (la_input & la_write);
            end else if (en_q[i]) begin
                if (!down_q[i]) begin
                    if (count_q[i] == limit_q[i]) begin
                        tc_set[i] = 1'b1;
                        if (oneshot_q[i]) en_d[i] = 1'b0;
                        else              count_d[i] = '0;
                    end else begin
                        count_d[i] = count_q[i] + 1'b1;
                    end
                end else begin
                    if (count_q[i] == '0) begin
                        tc_set[i] = 1'b1;
                        if (oneshot_q[i]) en_d[i] = 1'b0;
                        else              count_d[i] = limit_q[i];
                    end else begin
                        count_d[i] = count_q[i] - 1'b1;
                    end
                end
            end

            if (wr_hit[i] && reg_sel == REG_LIMIT) begin
                limit_d[i] = (limit_q[i] & ~lane_mask) | (wdata_bits & lane_mask);
            end

            if (wr_hit[i] && reg_sel == REG_CTRL && wstrb[0]) begin
                en_d[i]      = wdata[0];
                down_d[i]    = wdata[1];
                oneshot_d[i] = wdata[2];
                irq_en_d[i]  = wdata[3];
            end

            if (wr_hit[i] && reg_sel == REG_STATUS && wstrb[0] && wdata[0]) begin
                tc_d[i] = 1'b0;
            end
            if (tc_set[i]) begin
                tc_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready     <= 1'b0;
            rdata     <= '0;
            en_q      <= '0;
            down_q    <= '0;
            oneshot_q <= '0;
            irq_en_q  <= '0;
            tc_q      <= '0;
            for (int i = 0; i < NCH; i++) begin
                count_q[i] <= '0;
                limit_q[i] <= '1;
            end
        end else begin
            ready     <= access;
            rdata     <= access ? rd_val : 32'd0;
            en_q      <= en_d;
            down_q    <= down_d;
            oneshot_q <= oneshot_d;
            irq_en_q  <= irq_en_d;
            tc_q      <= tc_d;
            for (int i = 0; i < NCH; i++) begin
                count_q[i] <= count_d[i];
                limit_q[i] <= limit_d[i];
            end
        end
    end

    assign count0 = count_q[0];
    assign irq    = |(tc_q & irq_en_q);

endmodule

// File: tb/tb_wb_multi_counter.sv
// Directed bench for wb_multi_counter: bus reads are scored through a queue
// drained by a monitor on ready; pad/irq outputs are checked directly.
module tb_wb_multi_counter;

    localparam int BITS   = 16;
    localparam int NCH    = 4;
    localparam int ADDR_W = 8;

    logic              clk;
    logic              reset;
    logic              valid;
    logic [3:0]        wstrb;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              ready;
    logic [31:0]       rdata;
    logic [BITS-1:0]   la_write;
    logic [BITS-1:0]   la_input;
    logic [BITS-1:0]   count0;
    logic              irq;

    typedef struct {
        logic        check;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   assertions = 0;
    int   failures   = 0;

    wb_multi_counter #(.BITS(BITS), .NCH(NCH), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .valid    (valid),
        .wstrb    (wstrb),
        .addr     (addr),
        .wdata    (wdata),
        .ready    (ready),
        .rdata    (rdata),
        .la_write (la_write),
        .la_input (la_input),
        .count0   (count0),
        .irq      (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: every ready pulse consumes one scoreboard entry
    always @(negedge clk) begin
        if (ready === 1'b1) begin
            if (sb.size() == 0) begin
                assertions++;
                failures++;
                $display("[TB] FAIL unexpected_ready: got rdata=%h, required no ready", rdata);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.check) begin
                    assertions++;
                    if (rdata !== mon_e.exp) begin
                        failures++;
                        $display("[TB] FAIL %s: got %h, required %h", mon_e.name, rdata, mon_e.exp);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input string name, input logic [ADDR_W-1:0] a,
                                 input logic [3:0] s, input logic [31:0] d,
                                 input logic chk, input logic [31:0] exp,
                                 input logic [BITS-1:0] law, input logic [BITS-1:0] lai);
        bit got;
        @(posedge clk);
        #1;
        sb.push_back('{chk, exp, name});
        addr     = a;
        wstrb    = s;
        wdata    = d;
        la_write = law;
        la_input = lai;
        valid    = 1'b1;
        got      = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(posedge clk);
            #1;
            if (ready === 1'b1) got = 1'b1;
        end
        valid    = 1'b0;
        wstrb    = 4'b0000;
        la_write = '0;
        if (!got) begin
            assertions++;
            failures++;
            $display("[TB] FAIL %s_timeout: got no ready, required ready within 20 cycles", name);
        end
    endtask

    task automatic wr(input string name, input logic [ADDR_W-1:0] a, input logic [31:0] d);
        applyStimulus(name, a, 4'hF, d, 1'b0, 32'd0, '0, '0);
    endtask

    task automatic rd(input string name, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
        applyStimulus(name, a, 4'h0, 32'd0, 1'b1, exp, '0, '0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish, required finish before 200000");
        $fatal(1, "[TB] stopped");
    end

    logic [BITS-1:0] up_seq [5];
    logic            irq_seq [5];
    logic            hs_seq [6];

    initial begin
        up_seq  = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0};
        irq_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        hs_seq  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        reset    = 1'b0;
        valid    = 1'b0;
        wstrb    = 4'b0000;
        addr     = '0;
        wdata    = '0;
        la_write = '0;
        la_input = '0;
        #3 reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_count0", 32'(count0), 32'd0);
        checkOutput("reset_irq", 32'(irq), 32'd0);
        checkOutput("reset_ready", 32'(ready), 32'd0);
        checkOutput("reset_rdata", rdata, 32'd0);
        rd("reset_limit_ch1", 8'h14, 32'h0000FFFF);
        rd("reset_ctrl_ch0", 8'h08, 32'h0);

        // Up counting with wrap at LIMIT=3
        wr("lim0", 8'h04, 32'd3);
        wr("ctrl0", 8'h08, 32'h9);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("up_count0_%0d", i), 32'(count0), 32'(up_seq[i]));
            checkOutput($sformatf("up_irq_%0d", i), 32'(irq), 32'(irq_seq[i]));
        end
        rd("up_status0", 8'h0C, 32'h1);
        wr("ctrl0_stop", 8'h08, 32'h8);
        wr("status0_w1c", 8'h0C, 32'h1);
        checkOutput("w1c_irq", 32'(irq), 32'd0);
        checkOutput("stopped_count0", 32'(count0), 32'd0);
        rd("ctrl0_readback", 8'h08, 32'h8);

        // Down, one-shot on channel 2
        wr("lim2", 8'h24, 32'd5);
        wr("cnt2", 8'h20, 32'd2);
        wr("ctrl2", 8'h28, 32'h7);
        rd("down_count2_first", 8'h20, 32'd1);
        rd("down_count2_held", 8'h20, 32'd0);
        rd("oneshot_ctrl2", 8'h28, 32'h6);
        rd("oneshot_status2", 8'h2C, 32'h1);
        rd("oneshot_limit2", 8'h24, 32'd5);

        // Byte strobes, width truncation and out-of-range channels
        applyStimulus("cnt1_lane1", 8'h10, 4'b0010, 32'hAABBCCDD, 1'b0, 32'd0, '0, '0);
        rd("byte_count1", 8'h10, 32'h0000CC00);
        wr("cnt1_full", 8'h10, 32'hAABBCCDD);
        rd("trunc_count1", 8'h10, 32'h0000CCDD);
        rd("oob_read", 8'h80, 32'h0);
        wr("oob_write", 8'h84, 32'h1234);
        rd("oob_no_alias", 8'h04, 32'd3);

        // LA and bus priority on channel 0
        wr("lim0_max", 8'h04, 32'hFFFF);
        wr("cnt0_base", 8'h00, 32'h0500);
        wr("ctrl0_run", 8'h08, 32'h1);
        checkOutput("prio_start", 32'(count0), 32'h0500);
        la_write = 16'h00FF;
        la_input = 16'h1234;
        @(posedge clk);
        #1;
        la_write = '0;
        checkOutput("la_load", 32'(count0), 32'h0534);
        @(posedge clk);
        #1;
        checkOutput("after_la_step", 32'(count0), 32'h0535);
        applyStimulus("cnt0_bus_vs_la", 8'h00, 4'hF, 32'h0100, 1'b0, 32'd0, 16'hFFFF, 16'hBEEF);
        checkOutput("bus_beats_la", 32'(count0), 32'h0100);
        @(posedge clk);
        #1;
        checkOutput("bus_then_step", 32'(count0), 32'h0101);

        // valid held high: ready every other cycle
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) sb.push_back('{1'b1, 32'h0000FFFF, $sformatf("hs_read_%0d", i)});
        addr  = 8'h14;
        wstrb = 4'b0000;
        valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("hs_ready_%0d", i), 32'(ready), 32'(hs_seq[i]));
            if (i < 5) begin
                @(posedge clk);
                #1;
            end
        end
        valid = 1'b0;

        // LIMIT=0 up mode: tc every cycle, count stays 0
        wr("lim3_zero", 8'h34, 32'd0);
        wr("ctrl3", 8'h38, 32'h9);
        rd("zero_limit_count3", 8'h30, 32'd0);
        rd("zero_limit_status3", 8'h3C, 32'h1);
        wr("status3_w1c", 8'h3C, 32'h1);
        rd("zero_limit_status3_again", 8'h3C, 32'h1);
        checkOutput("irq_ch3", 32'(irq), 32'd1);

        // Reset during a pending acknowledge
        @(posedge clk);
        #1;
        addr  = 8'h00;
        valid = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ready_before_reset", 32'(ready), 32'd1);
        #1 reset = 1'b1;
        #1;
        valid = 1'b0;
        checkOutput("midreset_ready", 32'(ready), 32'd0);
        checkOutput("midreset_count0", 32'(count0), 32'd0);
        checkOutput("midreset_irq", 32'(irq), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rd("post_reset_limit_ch1", 8'h14, 32'h0000FFFF);
        rd("post_reset_ctrl_ch0", 8'h08, 32'h0);
        checkOutput("post_reset_count0", 32'(count0), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
